// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered 1-bit full adder cell.
// The master drives the operands; the slave (the adder) returns sum, carry and product terms.
interface full_adder_if;
  logic a_in;
  logic b_in;
  logic c_in;
  logic s_out;
  logic ca_out;
  logic a1_out;
  logic a2_out;
  logic a3_out;

  modport master (
    output a_in, b_in, c_in,
    input  s_out, ca_out, a1_out, a2_out, a3_out
  );

  modport slave (
    input  a_in, b_in, c_in,
    output s_out, ca_out, a1_out, a2_out, a3_out
  );
endinterface

// File: rtl/full_adder.sv
// Registered 1-bit full adder exporting its carry product terms; 1-cycle latency on all outputs.
// No handshake: one operand set accepted every cycle, never stalls.
module full_adder (
  input logic         clk_in,
  input logic         rst_n_in,
  full_adder_if.slave bus
);

  logic a1_nxt;
  logic a2_nxt;
  logic a3_nxt;

  assign a1_nxt = bus.a_in & bus.b_in;
  assign a2_nxt = bus.b_in & bus.c_in;
  assign a3_nxt = bus.a_in & bus.c_in;

  // Carry is built from the same product terms that get registered, so the
  // exported terms always OR to the registered carry.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.s_out  <= 1'b0;
      bus.ca_out <= 1'b0;
      bus.a1_out <= 1'b0;
      bus.a2_out <= 1'b0;
      bus.a3_out <= 1'b0;
    end else begin
      bus.s_out  <= bus.a_in ^ bus.b_in ^ bus.c_in;
      bus.ca_out <= a1_nxt | a2_nxt | a3_nxt;
      bus.a1_out <= a1_nxt;
      bus.a2_out <= a2_nxt;
      bus.a3_out <= a3_nxt;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of the registered full adder: reset, exhaustive table,
// latency, mid-stream async reset and per-cycle arithmetic invariants.
module tb_full_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  full_adder_if bus ();

  full_adder u_dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] abc);
    bus.a_in = abc[2];
    bus.b_in = abc[1];
    bus.c_in = abc[0];
  endtask

  // Wait for the next rising edge and step off it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] all_out();
    return {1'b0, bus.a1_out, bus.a2_out, bus.a3_out} | {2'b00, bus.ca_out, bus.s_out};
  endfunction

  logic [1:0] sum_tab  [8];
  logic [2:0] prod_tab [8];

  initial begin
    logic [2:0] prev;
    logic [2:0] cur;
    int         e;

    checks   = 0;
    failures = 0;

    sum_tab  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    prod_tab = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b001, 3'b100, 3'b111};

    // Reset held with all operands high: outputs are zero before any edge.
    rst_n = 1'b0;
    drive(3'b111);
    #2;
    check("rst_sum",  {2'b00, bus.ca_out, bus.s_out}, 4'b0000);
    check("rst_prod", {1'b0, bus.a1_out, bus.a2_out, bus.a3_out}, 4'b0000);
    tick();
    check("rst_edge", all_out(), 4'b0000);

    // Release between edges.
    #2;
    rst_n = 1'b1;

    // Exhaustive table, one combination per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(3'(i));
      tick();
      check($sformatf("exh_sum_%0d", i),  {2'b00, bus.ca_out, bus.s_out}, {2'b00, sum_tab[i]});
      check($sformatf("exh_prod_%0d", i), {1'b0, bus.a1_out, bus.a2_out, bus.a3_out}, {1'b0, prod_tab[i]});
    end

    // Latency: outputs hold the old result until the next rising edge.
    drive(3'b000);
    tick();
    check("lat_zero", all_out(), 4'b0000);
    drive(3'b111);
    #2;
    check("lat_hold", {2'b00, bus.ca_out, bus.s_out}, 4'b0000);
    tick();
    check("lat_upd", {2'b00, bus.ca_out, bus.s_out}, 4'b0011);

    // Mid-stream async reset while streaming 111.
    tick();
    check("mid_pre", {1'b0, bus.a1_out, bus.a2_out, bus.a3_out}, 4'b0111);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum",  {2'b00, bus.ca_out, bus.s_out}, 4'b0000);
    check("mid_rst_prod", {1'b0, bus.a1_out, bus.a2_out, bus.a3_out}, 4'b0000);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_rel_hold", all_out(), 4'b0000);
    tick();
    check("mid_post_sum",  {2'b00, bus.ca_out, bus.s_out}, 4'b0011);
    check("mid_post_prod", {1'b0, bus.a1_out, bus.a2_out, bus.a3_out}, 4'b0111);

    // Random stream: check arithmetic identity and carry consistency each cycle.
    prev = 3'b111;
    for (int n = 0; n < 1200; n++) begin
      cur = 3'($urandom_range(0, 7));
      drive(cur);
      tick();
      e = int'(cur[2]) + int'(cur[1]) + int'(cur[0]);
      check("rnd_sum",  {2'b00, bus.ca_out, bus.s_out}, 4'(e));
      check("rnd_prod", {1'b0, bus.a1_out, bus.a2_out, bus.a3_out},
            {1'b0, cur[2] & cur[1], cur[1] & cur[0], cur[2] & cur[0]});
      check("rnd_carry_or", {3'b000, bus.ca_out}, {3'b000, bus.a1_out | bus.a2_out | bus.a3_out});
      prev = cur;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
